// File: rtl/axis_rgb_packer_pkg.sv
// Shared types and helpers for the RGB888 dense packer: widths, FSM states,
// and the lane-keep / flush-word builders used on a partial final word.
package axis_rgb_pkg;

    localparam int PIX_W  = 24;
    localparam int WORD_W = 32;
    localparam int KEEP_W = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic logic [KEEP_W-1:0] keep_from_cnt(input logic [1:0] cnt);
        logic [KEEP_W-1:0] keep;
        case (cnt)
            2'd1:    keep = 4'h1;
            2'd2:    keep = 4'h3;
            2'd3:    keep = 4'h7;
            default: keep = 4'h0;
        endcase
        return keep;
    endfunction

    // Residual bytes fill the low lanes; lanes beyond the residue carry the pad value.
    function automatic logic [WORD_W-1:0] flush_word(input logic [PIX_W-1:0] res,
                                                     input logic [1:0]       cnt,
                                                     input logic [7:0]       pad);
        logic [WORD_W-1:0] ext;
        logic [WORD_W-1:0] word;
        logic [KEEP_W-1:0] keep;
        ext  = {8'h00, res};
        keep = keep_from_cnt(cnt);
        word = 32'h0000_0000;
        for (int i = 0; i < KEEP_W; i++) begin
            if (keep[i]) begin
                word[8*i +: 8] = ext[8*i +: 8];
            end else begin
                word[8*i +: 8] = pad;
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/axis_rgb_packer_if.sv
// AXI-Stream bundles for the packer: 24-bit pixel stream in, 32-bit packed
// word stream (with byte keep) out.
interface axis_pix_if;
    import axis_rgb_pkg::*;

    logic [PIX_W-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

interface axis_word_if;
    import axis_rgb_pkg::*;

    logic [WORD_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_rgb_packer_out_reg.sv
// Single-entry output holding register: accepts a word only when empty or
// draining this cycle, and keeps all fields stable while stalled.
module axis_out_reg
    import axis_rgb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    output logic              free,
    axis_word_if.master       m
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q,  data_d;
    logic [KEEP_W-1:0] keep_q,  keep_d;
    logic              last_q,  last_d;

    assign free = !valid_q || m.tready;

    // Next contents of the output register.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (load && free) begin
            valid_d = 1'b1;
            data_d  = load_data;
            keep_d  = load_keep;
            last_d  = load_last;
        end else if (m.tready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= 32'h0000_0000;
            keep_q  <= 4'h0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign m.tvalid = valid_q;
    assign m.tdata  = data_q;
    assign m.tkeep  = keep_q;
    assign m.tlast  = last_q;

endmodule

// File: rtl/axis_rgb_packer.sv
// Packs 24-bit pixels densely into 32-bit words (4 pixels -> 3 words) and
// flushes a padded, keep-marked partial word at the end of each packet.
module axis_rgb_packer
    import axis_rgb_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00,
    parameter bit         SWAP_RB  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    axis_pix_if.slave   in_AXIS,
    axis_word_if.master out_AXIS
);

    state_t            state_q,   state_d;
    logic [PIX_W-1:0]  res_q,     res_d;
    logic [1:0]        res_cnt_q, res_cnt_d;

    logic [PIX_W-1:0]  pix_s;
    logic              free_s;
    logic              ready_s;
    logic              load_s;
    logic [WORD_W-1:0] word_s;
    logic [KEEP_W-1:0] keep_s;
    logic              last_s;

    assign pix_s = SWAP_RB ? {in_AXIS.tdata[7:0], in_AXIS.tdata[15:8], in_AXIS.tdata[23:16]}
                           : in_AXIS.tdata;

    assign ready_s        = (state_q == RUN) && free_s;
    assign in_AXIS.tready = ready_s;

    // Pack/residual datapath and RUN/FLUSH next-state logic.
    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        res_cnt_d = res_cnt_q;
        load_s    = 1'b0;
        word_s    = 32'h0000_0000;
        keep_s    = 4'h0;
        last_s    = 1'b0;
        case (state_q)
            RUN: begin
                if (in_AXIS.tvalid && ready_s) begin
                    keep_s = 4'hF;
                    case (res_cnt_q)
                        2'd0: begin
                            res_d     = pix_s;
                            res_cnt_d = 2'd3;
                        end
                        2'd3: begin
                            load_s    = 1'b1;
                            word_s    = {pix_s[7:0], res_q};
                            res_d     = {8'h00, pix_s[23:8]};
                            res_cnt_d = 2'd2;
                        end
                        2'd2: begin
                            load_s    = 1'b1;
                            word_s    = {pix_s[15:0], res_q[15:0]};
                            res_d     = {16'h0000, pix_s[23:16]};
                            res_cnt_d = 2'd1;
                        end
                        default: begin
                            load_s    = 1'b1;
                            word_s    = {pix_s, res_q[7:0]};
                            res_d     = 24'h00_0000;
                            res_cnt_d = 2'd0;
                        end
                    endcase
                    // A packet ending mid-word finishes with a flush; otherwise its last word carries tlast.
                    if (in_AXIS.tlast && (res_cnt_d == 2'd0)) begin
                        last_s = 1'b1;
                    end else if (in_AXIS.tlast) begin
                        state_d = FLUSH;
                    end else begin
                        last_s = 1'b0;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            FLUSH: begin
                if (free_s) begin
                    load_s    = 1'b1;
                    word_s    = flush_word(res_q, res_cnt_q, PAD_BYTE);
                    keep_s    = keep_from_cnt(res_cnt_q);
                    last_s    = 1'b1;
                    res_d     = 24'h00_0000;
                    res_cnt_d = 2'd0;
                    state_d   = RUN;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // FSM and residue registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            res_q     <= 24'h00_0000;
            res_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    axis_out_reg u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .load_data (word_s),
        .load_keep (keep_s),
        .load_last (last_s),
        .free      (free_s),
        .m         (out_AXIS)
    );

endmodule
